core_endpoint: RTL and testbench



---
 rtl/core_endpoint_pkg.sv | 21 ++
 rtl/endpoint_vc_fifo.sv | 63 ++++++
 rtl/core_endpoint.sv | 144 ++++++++++++++
 tb/tb_core_endpoint.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_endpoint_pkg.sv
// rtl/core_endpoint_pkg.sv - flit types, field offsets and TX state encoding for core_endpoint
package core_endpoint_pkg;

    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEAD    = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    function automatic int type_lsb(input int data_width);
        return data_width - 2;
    endfunction

    function automatic int vc_lsb(input int data_width, input int vc_bits);
        return data_width - 2 - vc_bits;
    endfunction

endpackage

// File: rtl/endpoint_vc_fifo.sv
// rtl/endpoint_vc_fifo.sv - per-VC receive FIFO with registered empty/full status
module endpoint_vc_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  empty,
    output logic                  full,
    output logic                  drop
);
    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   count;
    logic [DEPTH_BITS:0]   count_next;
    logic                  do_pop;
    logic                  do_push;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign drop      = push && !do_push;
    assign head_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + (DEPTH_BITS+1)'(1);
        else if (!do_push && do_pop)
            count_next = count - (DEPTH_BITS+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + DEPTH_BITS'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + DEPTH_BITS'(1);
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == (DEPTH_BITS+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/core_endpoint.sv
// rtl/core_endpoint.sv - core-side packetizer and per-VC receive buffering for a router tile
module core_endpoint
    import core_endpoint_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int VC_BITS       = 1,
    parameter int VC_DEPTH_BITS = 2,
    parameter int ID_BITS       = 4,
    parameter int FLOW_BITS     = 8,
    parameter int LEN_BITS      = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            tx_req,
    input  logic [ID_BITS-1:0]              tx_dest,
    input  logic [FLOW_BITS-1:0]            tx_flow,
    input  logic [VC_BITS-1:0]              tx_vc,
    input  logic [LEN_BITS-1:0]             tx_len,
    output logic                            tx_busy,
    input  logic [DATA_WIDTH-3-VC_BITS:0]   tx_data,
    output logic                            tx_data_ready,
    output logic [DATA_WIDTH-1:0]           core_data_in,
    output logic                            core_valid_in,
    input  logic [(1<<VC_BITS)-1:0]         core_full_out,
    input  logic [DATA_WIDTH-1:0]           core_data_out,
    input  logic                            core_valid_out,
    output logic [(1<<VC_BITS)-1:0]         core_empty_in,
    output logic [(1<<VC_BITS)-1:0]         core_full_in,
    input  logic [VC_BITS-1:0]              rx_vc,
    input  logic                            rx_pop,
    output logic [DATA_WIDTH-1:0]           rx_flit,
    output logic                            rx_valid,
    output logic                            rx_overflow
);
    localparam int NUM_VCS = 1 << VC_BITS;
    localparam int PW      = DATA_WIDTH - 2 - VC_BITS;
    localparam int VC_LSB  = vc_lsb(DATA_WIDTH, VC_BITS);

    logic [1:0]           state;
    logic [ID_BITS-1:0]   dest_q;
    logic [FLOW_BITS-1:0] flow_q;
    logic [VC_BITS-1:0]   vc_q;
    logic [LEN_BITS-1:0]  cnt;
    logic                 stall;
    logic                 launch;
    logic [1:0]           ftype;
    logic [PW-1:0]        flit_low;

    assign stall         = core_full_out[vc_q];
    assign tx_busy       = (state != ST_IDLE);
    assign tx_data_ready = (state == ST_PAYLOAD) && !stall;

    always_comb begin
        launch   = 1'b0;
        ftype    = FT_BODY;
        flit_low = tx_data;
        case (state)
            ST_HEAD: begin
                launch   = !stall;
                ftype    = (cnt == '0) ? FT_SINGLE : FT_HEAD;
                flit_low = {{(PW-FLOW_BITS-ID_BITS){1'b0}}, flow_q, dest_q};
            end
            ST_PAYLOAD: begin
                launch = !stall;
                ftype  = (cnt == LEN_BITS'(1)) ? FT_TAIL : FT_BODY;
            end
            default: ;
        endcase
    end

    // cnt holds the latched length while in HEAD and counts remaining words in PAYLOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            core_valid_in <= 1'b0;
            core_data_in  <= '0;
            dest_q        <= '0;
            flow_q        <= '0;
            vc_q          <= '0;
            cnt           <= '0;
        end else begin
            core_valid_in <= launch;
            if (launch)
                core_data_in <= {ftype, vc_q, flit_low};
            case (state)
                ST_IDLE: begin
                    if (tx_req) begin
                        dest_q <= tx_dest;
                        flow_q <= tx_flow;
                        vc_q   <= tx_vc;
                        cnt    <= tx_len;
                        state  <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (!stall)
                        state <= (cnt == '0) ? ST_IDLE : ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (!stall) begin
                        cnt <= cnt - LEN_BITS'(1);
                        if (cnt == LEN_BITS'(1))
                            state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [VC_BITS-1:0]    in_vc;
    logic [NUM_VCS-1:0]    drop;
    logic [DATA_WIDTH-1:0] fifo_head [NUM_VCS];

    assign in_vc = core_data_out[VC_LSB +: VC_BITS];

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        endpoint_vc_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH_BITS (VC_DEPTH_BITS)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (core_valid_out && (in_vc == VC_BITS'(v))),
            .push_data (core_data_out),
            .pop       (rx_pop && (rx_vc == VC_BITS'(v))),
            .head_data (fifo_head[v]),
            .empty     (core_empty_in[v]),
            .full      (core_full_in[v]),
            .drop      (drop[v])
        );
    end

    assign rx_flit  = fifo_head[rx_vc];
    assign rx_valid = !core_empty_in[rx_vc];

    always_ff @(posedge clk) begin
        if (reset)
            rx_overflow <= 1'b0;
        else if (|drop)
            rx_overflow <= 1'b1;
    end

endmodule

// File: tb/tb_core_endpoint.sv
// tb/tb_core_endpoint.sv - randomized self-checking bench for core_endpoint
module tb_core_endpoint;
    localparam int DW = 32;
    localparam int PW = 29;

    logic          clk = 1'b0;
    logic          reset;
    logic          tx_req;
    logic [3:0]    tx_dest;
    logic [7:0]    tx_flow;
    logic          tx_vc;
    logic [3:0]    tx_len;
    logic          tx_busy;
    logic [PW-1:0] tx_data;
    logic          tx_data_ready;
    logic [DW-1:0] core_data_in;
    logic          core_valid_in;
    logic [1:0]    core_full_out;
    logic [DW-1:0] core_data_out;
    logic          core_valid_out;
    logic [1:0]    core_empty_in;
    logic [1:0]    core_full_in;
    logic          rx_vc;
    logic          rx_pop;
    logic [DW-1:0] rx_flit;
    logic          rx_valid;
    logic          rx_overflow;

    int checks = 0;
    int failures = 0;

    logic [31:0] rxq0[$];
    logic [31:0] rxq1[$];
    bit          model_ovf;

    always #5 clk = ~clk;

    core_endpoint dut (
        .clk(clk), .reset(reset), .tx_req(tx_req), .tx_dest(tx_dest), .tx_flow(tx_flow),
        .tx_vc(tx_vc), .tx_len(tx_len), .tx_busy(tx_busy), .tx_data(tx_data),
        .tx_data_ready(tx_data_ready), .core_data_in(core_data_in), .core_valid_in(core_valid_in),
        .core_full_out(core_full_out), .core_data_out(core_data_out), .core_valid_out(core_valid_out),
        .core_empty_in(core_empty_in), .core_full_in(core_full_in), .rx_vc(rx_vc), .rx_pop(rx_pop),
        .rx_flit(rx_flit), .rx_valid(rx_valid), .rx_overflow(rx_overflow)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic do_reset();
        tx_req = 0; tx_dest = 0; tx_flow = 0; tx_vc = 0; tx_len = 0; tx_data = 0;
        core_full_out = 0; core_data_out = 0; core_valid_out = 0; rx_vc = 0; rx_pop = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        rxq0.delete(); rxq1.delete(); model_ovf = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (core_valid_in !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", core_valid_in); end
        checks++; if (core_data_in !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", core_data_in); end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
        checks++; if (tx_data_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", tx_data_ready); end
        checks++; if (core_empty_in !== 2'b11) begin failures++; $display("FAIL reset_empty: got %b expected 11", core_empty_in); end
        checks++; if (core_full_in !== 2'b00) begin failures++; $display("FAIL reset_full: got %b expected 00", core_full_in); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", rx_overflow); end
    endtask

    // Sends one message and compares the flit stream to the packet rules; abort_at>=0
    // asserts reset once that many flits have appeared.
    task automatic run_msg(input logic [3:0] dest, input logic [7:0] flow, input logic vc,
                           input logic [3:0] len, input int stall_pct, input bit force_stall,
                           input int abort_at);
        logic [31:0]   exp[$];
        logic [PW-1:0] words[$];
        logic [31:0]   got[$];
        int            got_cyc[$];
        logic [31:0]   f;
        int            idx = 0;
        int            forced = 0;
        bit            prev_full = 0;
        bit            stalled_any = 0;
        bit            done = 0;

        f = '0;
        f[31:30] = (len == 0) ? 2'b11 : 2'b01;
        f[29] = vc;
        f[11:0] = {flow, dest};
        exp.push_back(f);
        for (int i = 0; i < int'(len); i++) begin
            words.push_back(PW'($urandom));
            f = {(i == int'(len) - 1) ? 2'b10 : 2'b00, vc, words[i]};
            exp.push_back(f);
        end

        tx_dest = dest; tx_flow = flow; tx_vc = vc; tx_len = len; tx_req = 1;
        @(posedge clk); #1 tx_req = 0;
        tx_dest = 4'($urandom); tx_flow = 8'($urandom); tx_vc = 1'($urandom); tx_len = 4'($urandom);
        checks++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL busy_after_req: got %b expected 1", tx_busy); end

        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            if (core_valid_in === 1'b1) begin
                got.push_back(core_data_in);
                got_cyc.push_back(cyc);
                checks++;
                if (prev_full) begin failures++; $display("FAIL launch_during_stall: got flit %h expected none", core_data_in); end
            end
            if (abort_at >= 0 && got.size() == abort_at) begin
                reset = 1;
                @(posedge clk); #1;
                checks++; if (core_valid_in !== 1'b0) begin failures++; $display("FAIL abort_valid: got %b expected 0", core_valid_in); end
                checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL abort_idle: got busy %b expected 0", tx_busy); end
                checks++; if (tx_data_ready !== 1'b0) begin failures++; $display("FAIL abort_ready: got %b expected 0", tx_data_ready); end
                reset = 0;
                core_full_out = 0;
                rxq0.delete(); rxq1.delete(); model_ovf = 0;
                return;
            end
            if (got.size() == int'(len) + 1) begin
                done = 1;
                checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL busy_after_last: got %b expected 0", tx_busy); end
            end else begin
                if (force_stall && idx == 1 && forced < 3) begin
                    core_full_out = 2'b00;
                    core_full_out[vc] = 1'b1;
                    forced++;
                end else begin
                    core_full_out[0] = ($urandom_range(0, 99) < stall_pct);
                    core_full_out[1] = ($urandom_range(0, 99) < stall_pct);
                end
                tx_data = (idx < int'(len)) ? words[idx] : PW'($urandom);
                #1;
                if (core_full_out[vc]) begin
                    checks++;
                    if (tx_data_ready !== 1'b0) begin failures++; $display("FAIL ready_during_stall: got %b expected 0", tx_data_ready); end
                end
                if (tx_data_ready === 1'b1) idx++;
                prev_full = core_full_out[vc];
                stalled_any |= prev_full;
            end
        end
        core_full_out = 0;

        checks++; if (!done) begin failures++; $display("FAIL msg_timeout: got %0d flits expected %0d", got.size(), exp.size()); end
        checks++; if (got.size() != exp.size()) begin failures++; $display("FAIL flit_count: got %0d expected %0d", got.size(), exp.size()); end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin failures++; $display("FAIL flit[%0d]: got %h expected %h", i, got[i], exp[i]); end
        end
        if (!stalled_any) begin
            for (int i = 0; i < got_cyc.size(); i++) begin
                checks++;
                if (got_cyc[i] != i + 1) begin failures++; $display("FAIL flit_latency[%0d]: got cycle %0d expected %0d", i, got_cyc[i], i + 1); end
            end
        end
    endtask

    task automatic test_basic_message();
        do_reset();
        run_msg(4'd5, 8'h3C, 1'b1, 4'd2, 0, 0, -1);
    endtask

    task automatic test_single_flit();
        run_msg(4'($urandom), 8'($urandom), 1'b0, 4'd0, 0, 0, -1);
        run_msg(4'($urandom), 8'($urandom), 1'b1, 4'd0, 0, 0, -1);
    endtask

    task automatic test_stall();
        run_msg(4'hA, 8'h55, 1'b1, 4'd5, 0, 1, -1);
    endtask

    task automatic test_back_to_back();
        for (int m = 0; m < 20; m++)
            run_msg(4'($urandom), 8'($urandom), 1'($urandom), 4'($urandom_range(0, 15)), 30, 0, -1);
    endtask

    task automatic test_reset_mid_payload();
        run_msg(4'd3, 8'h11, 1'b1, 4'd6, 0, 0, 3);
        run_msg(4'd7, 8'h22, 1'b0, 4'd3, 0, 0, -1);
    endtask

    // One RX cycle: checks the read port against the model, applies the edge, checks status.
    task automatic rx_cycle(input bit push, input logic pvc, input logic [31:0] pdata,
                            input bit pop, input logic pop_vc);
        logic [31:0] d;
        int          sz;
        bit          pop_ok;
        d = pdata;
        d[29] = pvc;
        core_valid_out = push; core_data_out = d; rx_pop = pop; rx_vc = pop_vc;
        #1;
        sz = pop_vc ? rxq1.size() : rxq0.size();
        checks++; if (rx_valid !== (sz != 0)) begin failures++; $display("FAIL rx_valid: got %b expected %b", rx_valid, sz != 0); end
        if (sz != 0) begin
            checks++;
            if (rx_flit !== (pop_vc ? rxq1[0] : rxq0[0])) begin
                failures++; $display("FAIL rx_flit: got %h expected %h", rx_flit, pop_vc ? rxq1[0] : rxq0[0]);
            end
        end
        pop_ok = pop && sz != 0;
        @(posedge clk); #1;
        if (pop_ok) begin
            if (pop_vc) void'(rxq1.pop_front()); else void'(rxq0.pop_front());
        end
        if (push) begin
            if ((pvc ? rxq1.size() : rxq0.size()) == 4) model_ovf = 1;
            else if (pvc) rxq1.push_back(d);
            else rxq0.push_back(d);
        end
        core_valid_out = 0; rx_pop = 0;
        checks++; if (core_empty_in !== {rxq1.size() == 0, rxq0.size() == 0}) begin failures++; $display("FAIL rx_empty: got %b expected %b", core_empty_in, {rxq1.size() == 0, rxq0.size() == 0}); end
        checks++; if (core_full_in !== {rxq1.size() == 4, rxq0.size() == 4}) begin failures++; $display("FAIL rx_full: got %b expected %b", core_full_in, {rxq1.size() == 4, rxq0.size() == 4}); end
        checks++; if (rx_overflow !== model_ovf) begin failures++; $display("FAIL rx_overflow: got %b expected %b", rx_overflow, model_ovf); end
    endtask

    task automatic test_rx_fill_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) rx_cycle(1, 1'b0, $urandom, 0, 1'b0);
        checks++; if (core_full_in[0] !== 1'b1) begin failures++; $display("FAIL fill_full: got %b expected 1", core_full_in[0]); end
        rx_cycle(1, 1'b0, $urandom, 0, 1'b0);
        checks++; if (rx_overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow: got %b expected 1", rx_overflow); end
        for (int i = 0; i < 5; i++) rx_cycle(0, 1'b0, 0, 1, 1'b0);
    endtask

    task automatic test_rx_push_pop_full();
        do_reset();
        for (int i = 0; i < 4; i++) rx_cycle(1, 1'b0, $urandom, 0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            rx_cycle(1, 1'b0, $urandom, 1, 1'b0);
            checks++; if (core_full_in[0] !== 1'b1) begin failures++; $display("FAIL pushpop_full: got %b expected 1", core_full_in[0]); end
        end
        for (int i = 0; i < 5; i++) rx_cycle(0, 1'b0, 0, 1, 1'b0);
    endtask

    task automatic test_rx_random();
        do_reset();
        for (int i = 0; i < 300; i++)
            rx_cycle($urandom_range(0, 99) < 60, 1'($urandom), $urandom,
                     $urandom_range(0, 99) < 45, 1'($urandom));
    endtask

    initial begin
        reset = 1;
        test_reset();
        test_basic_message();
        test_single_flit();
        test_stall();
        test_back_to_back();
        test_reset_mid_payload();
        test_rx_fill_overflow();
        test_rx_push_pop_full();
        test_rx_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
